// File: rtl/matmul_ctrl_part2_pkg.sv
// Shared types and constants for the 3x3 matrix-vector controller.
// FSM state encoding plus default sizing of the datapath.
package matmul_pkg_part2;

    typedef enum logic [2:0] {
        LOAD_W,
        LOAD_X,
        CLEAR,
        MAC,
        OUT
    } ctrl_state_t;

    localparam int N_DEF  = 3;
    localparam int DATA_W = 14;
    localparam int ACC_W  = 28;

endpackage

// File: rtl/matmul_ctrl_part2_if.sv
// Handshake and datapath-control bundle of the matmul controller.
// Optional keep_w input exists only when MATMUL_KEEP_W_EN is defined.
interface matmul_ctrl_part2_if #(
    parameter int ADDR_X_W = 2,
    parameter int ADDR_W_W = 4
);

    logic                in_valid;
    logic                in_ready;
    logic                out_ready;
    logic                out_valid;
    logic [ADDR_X_W-1:0] out_row;
    logic                busy;
    logic [ADDR_X_W-1:0] addr_x;
    logic                wr_en_x;
    logic [ADDR_W_W-1:0] addr_w;
    logic                wr_en_w;
    logic                clear_acc;
    logic                en_acc;
`ifdef MATMUL_KEEP_W_EN
    logic                keep_w;
`endif

    modport master (
`ifdef MATMUL_KEEP_W_EN
        input  keep_w,
`endif
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_row,
        output busy,
        output addr_x,
        output wr_en_x,
        output addr_w,
        output wr_en_w,
        output clear_acc,
        output en_acc
    );

    modport slave (
`ifdef MATMUL_KEEP_W_EN
        output keep_w,
`endif
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_row,
        input  busy,
        input  addr_x,
        input  wr_en_x,
        input  addr_w,
        input  wr_en_w,
        input  clear_acc,
        input  en_acc
    );

endinterface

// File: rtl/matmul_ctrl_part2.sv
// Sequencer for the NxN matrix-vector datapath: load W, load X, clear+MAC per row.
// Define MATMUL_KEEP_W_EN to add keep_w, letting a job reuse the stored weights.
module matmul_ctrl_part2
    import matmul_pkg_part2::*;
#(
    parameter int N        = N_DEF,
    parameter int ADDR_X_W = 2,
    parameter int ADDR_W_W = 4
) (
    input logic                 clk,
    input logic                 rst,
    matmul_ctrl_part2_if.master bus
);

    localparam logic [ADDR_W_W-1:0] W_LAST   = ADDR_W_W'(N*N-1);
    localparam logic [ADDR_W_W-1:0] X_LAST   = ADDR_W_W'(N-1);
    localparam logic [ADDR_X_W-1:0] IDX_LAST = ADDR_X_W'(N-1);
    localparam logic [ADDR_W_W-1:0] N_STEP   = ADDR_W_W'(N);

    ctrl_state_t         state;
    ctrl_state_t         state_nxt;
    logic [ADDR_W_W-1:0] cnt;
    logic [ADDR_X_W-1:0] row;
    logic [ADDR_X_W-1:0] k;
    logic [ADDR_W_W-1:0] row_base;
    logic                in_fire;
    logic                out_fire;
    logic                idle;

    assign in_fire  = bus.in_valid && !rst &&
                      (state == LOAD_W || state == LOAD_X);
    assign out_fire = bus.out_ready && !rst && (state == OUT);

`ifdef MATMUL_KEEP_W_EN
    logic kept;
    assign idle = (state == LOAD_W && cnt == '0) ||
                  (state == LOAD_X && cnt == '0 && kept);
`else
    assign idle = (state == LOAD_W && cnt == '0);
`endif

    assign bus.busy = !idle;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD_W;
        else     state <= state_nxt;
    end

    // Next-state decode driven by the two handshakes and the counters.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD_W: if (in_fire && cnt == W_LAST) state_nxt = LOAD_X;
            LOAD_X: if (in_fire && cnt == X_LAST) state_nxt = CLEAR;
            CLEAR:  state_nxt = MAC;
            MAC:    if (k == IDX_LAST) state_nxt = OUT;
            OUT: begin
                if (out_fire) begin
                    if (row != IDX_LAST) begin
                        state_nxt = CLEAR;
                    end else begin
`ifdef MATMUL_KEEP_W_EN
                        state_nxt = bus.keep_w ? LOAD_X : LOAD_W;
`else
                        state_nxt = LOAD_W;
`endif
                    end
                end
            end
            default: state_nxt = LOAD_W;
        endcase
    end

    // Element, row and column counters; row_base tracks N*row incrementally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            row      <= '0;
            k        <= '0;
            row_base <= '0;
`ifdef MATMUL_KEEP_W_EN
            kept     <= 1'b0;
`endif
        end else begin
            unique case (state)
                LOAD_W: begin
                    if (in_fire) cnt <= (cnt == W_LAST) ? '0 : cnt + 1'b1;
                end
                LOAD_X: begin
                    if (in_fire) begin
`ifdef MATMUL_KEEP_W_EN
                        kept <= 1'b0;
`endif
                        if (cnt == X_LAST) begin
                            cnt      <= '0;
                            row      <= '0;
                            row_base <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CLEAR: k <= '0;
                MAC:   k <= (k == IDX_LAST) ? '0 : k + 1'b1;
                OUT: begin
                    if (out_fire) begin
                        if (row != IDX_LAST) begin
                            row      <= row + 1'b1;
                            row_base <= row_base + N_STEP;
                        end else begin
                            row      <= '0;
                            row_base <= '0;
                            cnt      <= '0;
`ifdef MATMUL_KEEP_W_EN
                            kept     <= bus.keep_w;
`endif
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Per-state datapath controls; reset forces an accumulator clear only.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.wr_en_w   = 1'b0;
        bus.wr_en_x   = 1'b0;
        bus.addr_w    = '0;
        bus.addr_x    = '0;
        bus.clear_acc = 1'b0;
        bus.en_acc    = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_row   = '0;
        if (rst) begin
            bus.clear_acc = 1'b1;
        end else begin
            unique case (state)
                LOAD_W: begin
                    bus.in_ready = 1'b1;
                    bus.addr_w   = cnt;
                    bus.wr_en_w  = bus.in_valid;
                end
                LOAD_X: begin
                    bus.in_ready = 1'b1;
                    bus.addr_x   = cnt[ADDR_X_W-1:0];
                    bus.wr_en_x  = bus.in_valid;
                end
                CLEAR: bus.clear_acc = 1'b1;
                MAC: begin
                    bus.en_acc = 1'b1;
                    bus.addr_x = k;
                    bus.addr_w = row_base + ADDR_W_W'(k);
                end
                OUT: begin
                    bus.out_valid = 1'b1;
                    bus.out_row   = row;
                end
                default: bus.in_ready = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl_part2.sv
// Directed bench: controller plus a behavioural memory/MAC datapath model.
// Expected row results are hand-computed per job.
module tb_matmul_ctrl_part2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [13:0] din = '0;

    always #5 clk = ~clk;

    matmul_ctrl_part2_if #(.ADDR_X_W(2), .ADDR_W_W(4)) bus ();

    matmul_ctrl_part2 #(.N(3), .ADDR_X_W(2), .ADDR_W_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath model
    logic signed [13:0] mem_w [16];
    logic signed [13:0] mem_x [4];
    logic signed [27:0] acc = '0;
    logic signed [27:0] prod;
    logic signed [28:0] sum;
    int en_cnt = 0;
    int nw = 0;
    int nx = 0;
    int overlap = 0;

    function automatic logic signed [27:0] sat(input logic signed [28:0] s);
        if (s > 29'sd134217727) return 28'sh7FFFFFF;
        if (s < -29'sd134217728) return 28'sh8000000;
        return s[27:0];
    endfunction

    assign prod = mem_w[bus.addr_w] * mem_x[bus.addr_x];
    assign sum  = acc + prod;

    always @(posedge clk) begin
        if (bus.wr_en_w) begin mem_w[bus.addr_w] <= din; nw <= nw + 1; end
        if (bus.wr_en_x) begin mem_x[bus.addr_x] <= din; nx <= nx + 1; end
        if (bus.en_acc && bus.clear_acc) overlap <= overlap + 1;
        if (bus.clear_acc) begin
            acc <= '0;
            en_cnt <= 0;
        end else if (bus.en_acc) begin
            acc <= sat(sum);
            en_cnt <= en_cnt + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [13:0] v);
        int n = 0;
        bus.in_valid = 1'b1;
        din = v;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("in_ready_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic get_row(input int r, input logic signed [27:0] e, input int hold);
        int n = 0;
        while (!bus.out_valid && n < 40) begin tick(); n++; end
        chk("out_valid", bus.out_valid, 1);
        chk("out_row", bus.out_row, r);
        chk("row_data", acc, e);
        chk("en_per_row", en_cnt, 3);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", acc, e);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    logic signed [13:0] wv [9];
    logic signed [13:0] xv [3];
    logic signed [27:0] ev [3];
    logic keep_next = 1'b0;

    task automatic load(input bit load_w, input bit gaps);
        int nw0 = nw;
        int nx0 = nx;
        if (load_w) begin
            for (int i = 0; i < 9; i++) begin
                send(wv[i]);
                if (gaps && i == 3) tick();
            end
        end
        for (int i = 0; i < 3; i++) begin
            send(xv[i]);
            if (gaps && i == 0) tick();
        end
        chk("w_writes", nw - nw0, load_w ? 9 : 0);
        chk("x_writes", nx - nx0, 3);
        chk("in_ready_after_x", bus.in_ready, 0);
    endtask

    task automatic run_job(input bit load_w, input bit gaps, input int hold,
                           input bit timed);
        load(load_w, gaps);
        if (timed) begin
            chk("t1_clear", bus.clear_acc, 1);
            chk("t1_en", bus.en_acc, 0);
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("mac_en", bus.en_acc, 1);
                chk("mac_addr_w_r0", bus.addr_w, j);
                chk("mac_addr_x", bus.addr_x, j);
            end
            tick();
            chk("t5_out_valid", bus.out_valid, 1);
        end
        for (int r = 0; r < 3; r++) begin
`ifdef MATMUL_KEEP_W_EN
            bus.keep_w = (r == 2) ? keep_next : 1'b0;
`endif
            get_row(r, ev[r], hold);
            if (timed && r == 1) begin
                chk("r2_clear", bus.clear_acc, 1);
                for (int j = 0; j < 3; j++) begin
                    tick();
                    chk("mac_addr_w_r2", bus.addr_w, 6 + j);
                end
            end
        end
`ifdef MATMUL_KEEP_W_EN
        bus.keep_w = 1'b0;
`endif
    endtask

    task automatic set_ident();
        for (int i = 0; i < 9; i++) wv[i] = (i % 4 == 0) ? 14'sd1 : 14'sd0;
    endtask

    task automatic set_w123();
        for (int i = 0; i < 9; i++) wv[i] = 14'(i + 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
`ifdef MATMUL_KEEP_W_EN
        bus.keep_w = 1'b0;
`endif
        rst = 1'b1;
        tick();
        chk("rst_clear_acc", bus.clear_acc, 1);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_clear_rel", bus.clear_acc, 0);

        // Identity, with cycle-exact timing checks
        set_ident();
        xv = '{14'sd5, -14'sd7, 14'sd100};
        ev = '{28'sd5, -28'sd7, 28'sd100};
        run_job(1'b1, 1'b0, 0, 1'b1);
        chk("idle_busy", bus.busy, 0);

        // Positive saturation, with gaps and out backpressure
        for (int i = 0; i < 9; i++) wv[i] = 14'sd8191;
        xv = '{14'sd8191, 14'sd8191, 14'sd8191};
        ev = '{28'sd134217727, 28'sd134217727, 28'sd134217727};
        run_job(1'b1, 1'b1, 4, 1'b0);

        // Negative saturation
        xv = '{-14'sd8192, -14'sd8192, -14'sd8192};
        ev = '{-28'sd134217728, -28'sd134217728, -28'sd134217728};
        run_job(1'b1, 1'b0, 0, 1'b0);

        // Reset during row 1 MAC
        set_ident();
        xv = '{14'sd1, 14'sd2, 14'sd3};
        load(1'b1, 1'b0);
        get_row(0, 28'sd1, 0);
        tick();
        tick();
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_clear", bus.clear_acc, 1);
        chk("mid_rst_en", bus.en_acc, 0);
        tick();
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_acc", acc, 0);
        rst = 1'b0;
        #1;
        chk("mid_rel_in_ready", bus.in_ready, 1);

        // Fresh job after reset
        set_w123();
        xv = '{14'sd1, 14'sd1, 14'sd2};
        ev = '{28'sd9, 28'sd21, 28'sd33};
        run_job(1'b1, 1'b0, 0, 1'b0);

`ifdef MATMUL_KEEP_W_EN
        keep_next = 1'b1;
        run_job(1'b1, 1'b0, 0, 1'b0);
        keep_next = 1'b0;
        chk("keep_idle_busy", bus.busy, 0);
        chk("keep_in_ready", bus.in_ready, 1);
        xv = '{14'sd1, 14'sd2, 14'sd3};
        ev = '{28'sd14, 28'sd32, 28'sd50};
        run_job(1'b0, 1'b0, 0, 1'b0);
`endif

        chk("en_clear_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
